// File: rtl/add_sub_sched.sv
// add_sub_sched: round-robin scheduler sharing one 4-bit two's-complement
// adder-subtractor between two valid/ready requesters. Each operation
// walks IDLE (grant + operand capture) -> EXEC (compute + result capture)
// -> HOLD (present until the consumer accepts).

// Shared datapath: s = a + (b ^ {4{sub}}) + sub, with signed overflow taken
// as carry-into-msb XOR carry-out-of-msb.
module add_sub_dp (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       sub_i,
  output logic [3:0] s_o,
  output logic       ovf_o
);
  logic [3:0] bx;
  logic [3:0] lo;   // low three bits plus carry into bit 3
  logic [1:0] hi;   // bit 3 plus carry out of bit 3

  // Split the add at bit 3 so both carries around the msb are visible.
  always_comb begin
    bx    = b_i ^ {4{sub_i}};
    lo    = {1'b0, a_i[2:0]} + {1'b0, bx[2:0]} + {3'b000, sub_i};
    hi    = {1'b0, a_i[3]} + {1'b0, bx[3]} + {1'b0, lo[3]};
    s_o   = {hi[0], lo[2:0]};
    ovf_o = lo[3] ^ hi[1];
  end
endmodule

module add_sub_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req0_sub,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic       req1_sub,
  output logic       req1_ready,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_id,
  output logic [3:0] res_s,
  output logic       res_ovf,
  output logic [7:0] ovf_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t     state_q, state_d;
  logic [3:0] op_a_q, op_b_q;
  logic       op_sub_q, op_id_q;
  logic       res_valid_q, res_id_q, res_ovf_q;
  logic [3:0] res_s_q;
  logic [7:0] ovf_cnt_q;
  logic       last_grant_q;

  logic       gnt0, gnt1;
  logic       load_op, load_res, accept;
  logic [3:0] dp_s;
  logic       dp_ovf;

  add_sub_dp u_dp (
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .sub_i (op_sub_q),
    .s_o   (dp_s),
    .ovf_o (dp_ovf)
  );

  // Arbitration: only in IDLE, never under reset; ties go to the requester
  // that was not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req0_valid && (!req1_valid || last_grant_q)) gnt0 = 1'b1;
      else if (req1_valid)                             gnt1 = 1'b1;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_d  = state_q;
    load_op  = 1'b0;
    load_res = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: if (gnt0 || gnt1) begin
        load_op = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        load_res = 1'b1;
        state_d  = HOLD;
      end
      HOLD: if (res_ready) begin
        accept  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture on grant, result capture in EXEC, bookkeeping on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sub_q     <= 1'b0;
      op_id_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_s_q      <= '0;
      res_ovf_q    <= 1'b0;
      ovf_cnt_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      if (load_op) begin
        op_a_q   <= gnt1 ? req1_a   : req0_a;
        op_b_q   <= gnt1 ? req1_b   : req0_b;
        op_sub_q <= gnt1 ? req1_sub : req0_sub;
        op_id_q  <= gnt1;
      end
      if (load_res) begin
        res_s_q     <= dp_s;
        res_ovf_q   <= dp_ovf;
        res_id_q    <= op_id_q;
        res_valid_q <= 1'b1;
      end
      if (accept) begin
        res_valid_q  <= 1'b0;
        last_grant_q <= res_id_q;
        if (res_ovf_q && ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_s      = res_s_q;
  assign res_ovf    = res_ovf_q;
  assign ovf_cnt    = ovf_cnt_q;
endmodule

// File: tb/tb_add_sub_sched.sv
// Scoreboard bench for add_sub_sched: the stimulus side predicts grants from
// round-robin rules and queues the arithmetic result of each granted
// operation; an independent monitor checks every presented result.
module tb_add_sub_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       req0_sub = 1'b0, req1_sub = 1'b0;
  logic       req0_ready, req1_ready;
  logic       res_valid, res_id, res_ovf;
  logic       res_ready = 1'b0;
  logic [3:0] res_s;
  logic [7:0] ovf_cnt;

  add_sub_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_s(res_s), .res_ovf(res_ovf), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s;
    logic       ovf;
    logic       id;
    int         gcyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, n_ops = 0, cnt = 0;
  bit   busy = 0, last_g = 1;
  int   rr_pct = 100, gen_pct = 0;
  bit   gen_en[2] = '{0, 0};
  bit   ovf_mode = 0;
  bit   v[2] = '{0, 0};
  logic [3:0] va[2], vb[2];
  logic       vs[2];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  // Reference: true signed result, wrapped to 4 bits, overflow by range.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b,
                                 input logic sub, input logic id, input int gc);
    exp_t r;
    int   x;
    x = sub ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
    r.s    = 4'(x);
    r.ovf  = (x < -8) || (x > 7);
    r.id   = id;
    r.gcyc = gc;
    return r;
  endfunction

  // One clock of stimulus: drive at +1, check grants at +2.
  task automatic cycle(input bit do_rst);
    bit e0, e1, g;
    @(posedge clk); #1;
    cyc++;
    rst = do_rst;
    for (int r = 0; r < 2; r++)
      if (!v[r] && gen_en[r] && $urandom_range(99) < gen_pct) begin
        v[r] = 1;
        if (ovf_mode) begin
          if ($urandom_range(1) == 0) begin va[r] = 4'd7; vb[r] = 4'($urandom_range(1, 7)); vs[r] = 0; end
          else                        begin va[r] = 4'd8; vb[r] = 4'($urandom_range(1, 7)); vs[r] = 1; end
        end else begin
          va[r] = 4'($urandom); vb[r] = 4'($urandom); vs[r] = 1'($urandom);
        end
      end
    req0_valid = v[0]; req0_a = va[0]; req0_b = vb[0]; req0_sub = vs[0];
    req1_valid = v[1]; req1_a = va[1]; req1_b = vb[1]; req1_sub = vs[1];
    #1;
    if (do_rst) begin
      chk("req0_ready_in_reset", req0_ready, 0);
      chk("req1_ready_in_reset", req1_ready, 0);
      q.delete();
      busy = 0; last_g = 1; cnt = 0;
    end else begin
      e0 = !busy && v[0] && (!v[1] || last_g);
      e1 = !busy && v[1] && (!v[0] || !last_g);
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      if (e0 || e1) begin
        g = e1;
        q.push_back(model(va[g], vb[g], vs[g], g, cyc));
        busy = 1;
        v[g] = 0;
        n_ops++;
      end
    end
  endtask

  task automatic set_req(input int r, input logic [3:0] a, input logic [3:0] b, input logic sub);
    v[r] = 1; va[r] = a; vb[r] = b; vs[r] = sub;
  endtask

  // Run until nothing is pending or outstanding.
  task automatic drain(input string nm, input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      cycle(0);
      if (!v[0] && !v[1] && q.size() == 0) break;
    end
    if (k == bound) timeout(nm);
  endtask

  task automatic wait_grant(input string nm);
    int k;
    for (k = 0; k < 20; k++) begin
      cycle(0);
      if (busy) break;
    end
    if (k == 20) timeout(nm);
  endtask

  // Monitor: drives res_ready at +1, checks the result side at +3.
  initial begin
    bit   ev;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      res_ready = ($urandom_range(99) < rr_pct);
      #2;
      if (!rst) begin
        ev = (q.size() != 0) && (cyc >= q[0].gcyc + 2);
        chk("res_valid", res_valid, ev);
        chk("ovf_cnt", ovf_cnt, cnt);
        if (ev) begin
          chk("res_s", res_s, q[0].s);
          chk("res_ovf", res_ovf, q[0].ovf);
          chk("res_id", res_id, q[0].id);
          if (res_ready) begin
            e = q.pop_front();
            busy = 0;
            last_g = e.id;
            if (e.ovf && cnt < 255) cnt++;
          end
        end
      end
    end
  end

  initial begin
    int start;
    // Reset values.
    set_req(0, 4'd3, 4'd4, 1'b0);
    cycle(1); cycle(1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_s", res_s, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_ovf", res_ovf, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);

    // Directed arithmetic cases.
    rr_pct = 100;
    drain("single_add", 40);
    set_req(1, 4'd7, 4'd1, 1'b0); drain("ovf_7p1", 40);
    set_req(1, 4'd8, 4'd1, 1'b1); drain("ovf_m8m1", 40);
    set_req(0, 4'd5, 4'd5, 1'b1); drain("5m5", 40);
    set_req(0, 4'd8, 4'd8, 1'b0); drain("m8pm8", 40);
    chk("ovf_cnt_after_directed", ovf_cnt, 3);

    // Reset in EXEC: last served is 0, so req1 wins this tie; after reset req0 must.
    set_req(0, 4'd7, 4'd2, 1'b0); set_req(1, 4'd7, 4'd3, 1'b0);
    wait_grant("grant_before_exec_rst");
    cycle(1);
    set_req(0, 4'd1, 4'd1, 1'b0); set_req(1, 4'd2, 4'd2, 1'b0);
    cycle(0);
    chk("exec_rst_res_valid", res_valid, 0);
    chk("exec_rst_ovf_cnt", ovf_cnt, 0);
    drain("after_exec_rst", 40);

    // Reset in HOLD under backpressure.
    rr_pct = 0;
    set_req(0, 4'd7, 4'd5, 1'b0); set_req(1, 4'd7, 4'd6, 1'b0);
    wait_grant("grant_before_hold_rst");
    cycle(0); cycle(0);
    cycle(1);
    rr_pct = 100;
    set_req(0, 4'd2, 4'd3, 1'b1); set_req(1, 4'd4, 4'd4, 1'b1);
    cycle(0);
    chk("hold_rst_res_valid", res_valid, 0);
    chk("hold_rst_ovf_cnt", ovf_cnt, 0);
    drain("after_hold_rst", 40);

    // Backpressure: ten-plus cycles stalled in HOLD with a new req0 waiting.
    rr_pct = 0;
    set_req(0, 4'd6, 4'd3, 1'b0);
    wait_grant("grant_backpressure");
    set_req(0, 4'd1, 4'd2, 1'b1);
    for (int i = 0; i < 12; i++) cycle(0);
    rr_pct = 100;
    drain("backpressure_drain", 40);

    // Contention from reset: grant order 0,1,0,1.
    cycle(1);
    gen_en = '{1, 1}; gen_pct = 100;
    start = n_ops;
    for (int k = 0; k < 60 && n_ops - start < 4; k++) cycle(0);
    if (n_ops - start < 4) timeout("contention");
    gen_en = '{0, 0};
    drain("contention_drain", 40);

    // Random traffic with random backpressure.
    gen_en = '{1, 1}; gen_pct = 40; rr_pct = 60;
    for (int i = 0; i < 400; i++) cycle(0);
    gen_en = '{0, 0}; rr_pct = 100;
    drain("random_drain", 60);

    // Saturation: 260 overflowing operations.
    gen_en = '{1, 1}; gen_pct = 100; ovf_mode = 1;
    start = n_ops;
    for (int k = 0; k < 3000 && n_ops - start < 260; k++) cycle(0);
    if (n_ops - start < 260) timeout("saturation");
    gen_en = '{0, 0};
    drain("saturation_drain", 40);
    cycle(0);
    chk("ovf_cnt_saturated", ovf_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
